ast_pkt_rr_arbiter: RTL and testbench
=====================================

// Module: ast_pkt_rr_arbiter
// PURPOSE
//  Packet-aware round-robin arbiter merging IN_DIRS_CNT Avalon-ST sinks into one Avalon-ST source.
//  Grant is locked from the accepted startofpacket beat through the accepted endofpacket beat,
//  so packets are never interleaved. Sits between the per-size string FIFOs and the output
//  port of the string pipeline. Gives fair, packet-granular service to every string size.
// PARAMETERS
//  BYTE_W        8   bits per symbol
//  IN_DIRS_CNT   4   number of requesting sinks (>=2)
//  AST_SYMBOLS   1   symbols per beat
//  AST_EMPTY_W   1   empty width: 1 if AST_SYMBOLS==1, else $clog2(AST_SYMBOLS)
//  TIMEOUT_CYC   64  stall limit in cycles, used only with ARB_PKT_TIMEOUT_EN
// PORTS
//  clk_i                       in   1                              clock
//  rst_i                       in   1                              reset, asynchronous, active-high
//  ast_sink_data_i             in   [IN_DIRS_CNT][AST_SYMBOLS][BYTE_W]  per-sink data
//  ast_sink_valid_i            in   [IN_DIRS_CNT]                  per-sink valid
//  ast_sink_ready_o            out  [IN_DIRS_CNT]                  per-sink ready
//  ast_sink_empty_i            in   [IN_DIRS_CNT][AST_EMPTY_W]     per-sink empty
//  ast_sink_startofpacket_i    in   [IN_DIRS_CNT]                  per-sink SOP
//  ast_sink_endofpacket_i      in   [IN_DIRS_CNT]                  per-sink EOP
//  ast_source_data_o           out  [AST_SYMBOLS][BYTE_W]          merged data
//  ast_source_valid_o          out  1                              merged valid
//  ast_source_ready_i          in   1                              downstream ready
//  ast_source_empty_o          out  AST_EMPTY_W                    merged empty
//  ast_source_startofpacket_o  out  1                              merged SOP
//  ast_source_endofpacket_o    out  1                              merged EOP
//  grant_o                     out  IN_DIRS_CNT                    one-hot current grant, 0 in IDLE
//  timeout_o                   out  1                              1-cycle pulse on forced release (macro only)
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, rr_ptr=0, all ready_o=0, source valid/sop/eop=0, data/empty=0, timeout_o=0.
//  - States: IDLE (no grant) and LOCK (one-hot grant held).
//  - IDLE: if any sink_valid, pick the first valid index searching circularly from rr_ptr.
//    Register the grant and go to LOCK. One bubble cycle per packet. No sink is ready in IDLE.
//  - LOCK: source_* = granted sink's signals (combinational mux).
//    ready_o[g] = ast_source_ready_i; other ready_o=0.
//    A beat transfers when valid&&ready on the source.
//  - Release: on a transferred beat with EOP=1, go to IDLE, set rr_ptr=(g+1) mod IN_DIRS_CNT, grant=0.
//    Single-beat packets (SOP&EOP) lock for exactly one transfer.
//  - Missing SOP: a granted first beat without SOP is forwarded unchanged; no SOP checking.
//  - Mid-packet SOP: a repeated SOP mid-packet is forwarded unchanged; lock is held until EOP.
//  - Ungranted sinks: valid may toggle freely; they see ready=0 and are never lost.
//  - Sink valid drop: granted sink dropping valid mid-packet holds LOCK (source_valid=0).
//  - Back-to-back: same sink re-requests after EOP -> it wins only if no other valid lies between rr_ptr and it.
//  - Reset mid-packet: immediate return to reset state; a partial packet is truncated on the output.
//    Downstream must tolerate this.
//  - rr_ptr width: $clog2(IN_DIRS_CNT); wrap from IN_DIRS_CNT-1 to 0.
// CONFIGURATION
//  ARB_PKT_TIMEOUT_EN defined:
//   - A stall counter ($clog2(TIMEOUT_CYC+1) bits) counts LOCK cycles where the granted sink valid=0.
//     It clears on any transfer.
//   - On reaching TIMEOUT_CYC: pulse timeout_o for 1 cycle, go to IDLE, advance rr_ptr past g.
//     The next output beat may lack SOP.
//  ARB_PKT_TIMEOUT_EN undefined:
//   - No counter; timeout_o tied 0; LOCK is held indefinitely until EOP.
// TESTING
//  1 Sinks 0..3 each hold a 3-beat packet, source ready=1 -> packet order 0,1,2,3.
//    Each packet is 3 contiguous beats; 1 idle cycle between packets.
//  2 Sink 2 sends a 5-beat packet while sink 0 is valid throughout -> no sink-0 beat appears before sink-2 EOP.
//    Sink 0 is granted next.
//  3 Source ready toggles 1/0 every cycle during a 4-beat packet -> 4 beats transferred, data in order.
//    ready_o[g] mirrors ready_i.
//  4 rst_i asserted asynchronously on beat 2 of a packet -> all outputs 0 in the same cycle.
//    After release, arbitration restarts at rr_ptr=0.
//  5 Only sink 1 valid, repeated single-beat packets -> grants 1,1,1, each with 1 bubble; rr_ptr=2 after each.
//  6 [ARB_PKT_TIMEOUT_EN, TIMEOUT_CYC=8] Granted sink drops valid after SOP -> timeout_o pulses on stall cycle 8.
//    Next valid sink is granted.

Source files
------------

// File: rtl/ast_pkt_rr_arbiter_if.sv
// Avalon-ST bundle for the packet arbiter: IN_DIRS_CNT sink lanes in, one merged source out.
// The slave modport is the arbiter's view; the master modport is the view of the logic around it.
interface ast_pkt_rr_arbiter_if #(
  parameter int BYTE_W      = 8,
  parameter int IN_DIRS_CNT = 4,
  parameter int AST_SYMBOLS = 1,
  parameter int AST_EMPTY_W = 1
);
  logic [IN_DIRS_CNT-1:0][AST_SYMBOLS-1:0][BYTE_W-1:0] ast_sink_data_i;
  logic [IN_DIRS_CNT-1:0]                              ast_sink_valid_i;
  logic [IN_DIRS_CNT-1:0]                              ast_sink_ready_o;
  logic [IN_DIRS_CNT-1:0][AST_EMPTY_W-1:0]             ast_sink_empty_i;
  logic [IN_DIRS_CNT-1:0]                              ast_sink_startofpacket_i;
  logic [IN_DIRS_CNT-1:0]                              ast_sink_endofpacket_i;

  logic [AST_SYMBOLS-1:0][BYTE_W-1:0]                  ast_source_data_o;
  logic                                                ast_source_valid_o;
  logic                                                ast_source_ready_i;
  logic [AST_EMPTY_W-1:0]                              ast_source_empty_o;
  logic                                                ast_source_startofpacket_o;
  logic                                                ast_source_endofpacket_o;

  modport slave (
    input  ast_sink_data_i, ast_sink_valid_i, ast_sink_empty_i,
    input  ast_sink_startofpacket_i, ast_sink_endofpacket_i,
    output ast_sink_ready_o,
    output ast_source_data_o, ast_source_valid_o, ast_source_empty_o,
    output ast_source_startofpacket_o, ast_source_endofpacket_o,
    input  ast_source_ready_i
  );

  modport master (
    output ast_sink_data_i, ast_sink_valid_i, ast_sink_empty_i,
    output ast_sink_startofpacket_i, ast_sink_endofpacket_i,
    input  ast_sink_ready_o,
    input  ast_source_data_o, ast_source_valid_o, ast_source_empty_o,
    input  ast_source_startofpacket_o, ast_source_endofpacket_o,
    output ast_source_ready_i
  );
endinterface

// File: rtl/ast_pkt_rr_arbiter.sv
// Packet-locked round-robin merge of IN_DIRS_CNT Avalon-ST sinks; one bubble per packet, then a comb path with ready passed through.
// Optional stall watchdog via `ARB_PKT_TIMEOUT_EN releases a lock whose sink stays silent for TIMEOUT_CYC cycles.
module ast_pkt_rr_arbiter #(
  parameter int BYTE_W      = 8,
  parameter int IN_DIRS_CNT = 4,
  parameter int AST_SYMBOLS = 1,
  parameter int AST_EMPTY_W = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  ast_pkt_rr_arbiter_if.slave    ast_if,
  output logic [IN_DIRS_CNT-1:0] grant_o,
  output logic                   timeout_o
);
  localparam int PTR_W = $clog2(IN_DIRS_CNT);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e                 state_q, state_d;
  logic [IN_DIRS_CNT-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       pick_idx;
  logic [PTR_W-1:0]       ptr_after_gnt;
  logic                   pick_vld;
  logic                   gnt_vld;
  logic                   xfer;
  logic                   stall_expire;

  assign gnt_vld       = (state_q == LOCK) && ast_if.ast_sink_valid_i[gnt_idx_q];
  assign xfer          = gnt_vld && ast_if.ast_source_ready_i;
  assign ptr_after_gnt = (gnt_idx_q == PTR_W'(IN_DIRS_CNT - 1)) ? '0 : gnt_idx_q + 1'b1;

  // First valid sink at or after rr_ptr, wrapping around.
  always_comb begin
    int k;
    k        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < IN_DIRS_CNT; i++) begin
      k = int'(rr_ptr_q) + i;
      if (k >= IN_DIRS_CNT) k = k - IN_DIRS_CNT;
      if (!pick_vld && ast_if.ast_sink_valid_i[k]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(k);
      end
    end
  end

`ifdef ARB_PKT_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q != LOCK || xfer) stall_d = '0;
    else if (!gnt_vld)           stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_expire = (state_q == LOCK) && !gnt_vld && (stall_q == STALL_W'(TIMEOUT_CYC - 1));
`else
  assign stall_expire = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d             = LOCK;
          gnt_idx_d           = pick_idx;
          grant_d             = '0;
          grant_d[pick_idx]   = 1'b1;
        end
      end
      LOCK: begin
        if ((xfer && ast_if.ast_sink_endofpacket_i[gnt_idx_q]) || stall_expire) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = ptr_after_gnt;
        end
      end
    endcase
  end

  // Source side is a pure mux of the locked sink; everything is forced to zero while idle.
  always_comb begin
    ast_if.ast_source_data_o          = '0;
    ast_if.ast_source_valid_o         = 1'b0;
    ast_if.ast_source_empty_o         = '0;
    ast_if.ast_source_startofpacket_o = 1'b0;
    ast_if.ast_source_endofpacket_o   = 1'b0;
    ast_if.ast_sink_ready_o           = '0;
    if (state_q == LOCK) begin
      ast_if.ast_source_data_o                = ast_if.ast_sink_data_i[gnt_idx_q];
      ast_if.ast_source_valid_o               = gnt_vld;
      ast_if.ast_source_empty_o               = ast_if.ast_sink_empty_i[gnt_idx_q];
      ast_if.ast_source_startofpacket_o       = ast_if.ast_sink_startofpacket_i[gnt_idx_q];
      ast_if.ast_source_endofpacket_o         = ast_if.ast_sink_endofpacket_i[gnt_idx_q];
      ast_if.ast_sink_ready_o[gnt_idx_q]      = ast_if.ast_source_ready_i;
    end
    grant_o   = grant_q;
    timeout_o = stall_expire;
  end
endmodule

// File: tb/tb_ast_pkt_rr_arbiter.sv
// Directed bench for ast_pkt_rr_arbiter: sink packet generators, source beat log, hand-derived expectations.
module tb_ast_pkt_rr_arbiter;
  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] grant_o;
  logic         timeout_o;

  ast_pkt_rr_arbiter_if #(.BYTE_W(8), .IN_DIRS_CNT(N), .AST_SYMBOLS(1), .AST_EMPTY_W(1)) ast_if ();

  ast_pkt_rr_arbiter #(
    .BYTE_W(8), .IN_DIRS_CNT(N), .AST_SYMBOLS(1), .AST_EMPTY_W(1), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ast_if    (ast_if.slave),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic       sop;
    logic       eop;
    logic [7:0] d;
  } rec_t;

  rec_t q[$];
  int   len[N], beat[N], pk[N], reps[N];
  bit   en[N], hold_after_sop[N], held[N], pend[N];
  bit   tog_rdy;
  int   cyc, n_chk, n_fail, to_pulses, to_cyc, mirror_err;

  function automatic logic [7:0] dat_of(input int s, input int p, input int b);
    return 8'(s * 64 + (p % 4) * 16 + b);
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      ast_if.ast_sink_valid_i[s]         = en[s] && !held[s];
      ast_if.ast_sink_data_i[s][0]       = dat_of(s, pk[s], beat[s]);
      ast_if.ast_sink_empty_i[s]         = 1'b0;
      ast_if.ast_sink_startofpacket_i[s] = (beat[s] == 0);
      ast_if.ast_sink_endofpacket_i[s]   = (beat[s] == len[s] - 1);
    end
    ast_if.ast_source_ready_i = tog_rdy ? ~ast_if.ast_source_ready_i : 1'b1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    for (int s = 0; s < N; s++) begin
      if (pend[s]) begin
        pend[s] = 1'b0;
        if (hold_after_sop[s] && beat[s] == 0) held[s] = 1'b1;
        beat[s]++;
        if (beat[s] >= len[s]) begin
          beat[s] = 0;
          pk[s]++;
          reps[s]--;
          if (reps[s] <= 0) en[s] = 1'b0;
        end
      end
    end
    cyc++;
    drive();
    @(negedge clk_i);
    for (int s = 0; s < N; s++)
      pend[s] = ast_if.ast_sink_valid_i[s] && ast_if.ast_sink_ready_o[s];
    if (ast_if.ast_source_valid_o && ast_if.ast_source_ready_i)
      q.push_back('{cyc, grant_o, ast_if.ast_source_startofpacket_o,
                    ast_if.ast_source_endofpacket_o, ast_if.ast_source_data_o[0]});
    if (timeout_o) begin
      to_pulses++;
      to_cyc = cyc;
    end
    if (grant_o != '0)
      for (int s = 0; s < N; s++)
        if (ast_if.ast_sink_ready_o[s] !== (grant_o[s] ? ast_if.ast_source_ready_i : 1'b0))
          mirror_err++;
  endtask

  task automatic run_until(input int n, input int budget);
    int b;
    b = 0;
    while (q.size() < n && b < budget) begin
      step();
      b++;
    end
    chk_eq("beat_count", q.size(), n);
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [3:0] g,
                          input int s, input int p, input int b, input logic sop, input logic eop);
    if (i < q.size())
      chk_eq(tag, {q[i].g, q[i].sop, q[i].eop, q[i].d}, {g, sop, eop, dat_of(s, p, b)});
    else
      chk_eq({tag, "_missing"}, q.size(), i + 1);
  endtask

  task automatic start_pkt(input int s, input int l, input int r);
    len[s]  = l;
    reps[s] = r;
    beat[s] = 0;
    en[s]   = 1'b1;
  endtask

  initial begin
    for (int s = 0; s < N; s++) begin
      len[s] = 1; beat[s] = 0; pk[s] = 0; reps[s] = 0;
      en[s] = 0; hold_after_sop[s] = 0; held[s] = 0; pend[s] = 0;
    end
    tog_rdy = 0; cyc = 0; n_chk = 0; n_fail = 0; to_pulses = 0; to_cyc = 0; mirror_err = 0;
    ast_if.ast_source_ready_i = 1'b1;

    // Reset with every sink already presenting a 3-beat packet.
    for (int s = 0; s < N; s++) start_pkt(s, 3, 1);
    drive();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_eq("rst_grant", grant_o, 4'b0000);
    chk_eq("rst_src", {ast_if.ast_source_valid_o, ast_if.ast_source_startofpacket_o,
                       ast_if.ast_source_endofpacket_o, ast_if.ast_source_empty_o,
                       ast_if.ast_source_data_o}, 12'h000);
    chk_eq("rst_sink_rdy", ast_if.ast_sink_ready_o, 4'b0000);
    chk_eq("rst_timeout", timeout_o, 1'b0);
    rst_i = 1'b0;

    // Packets in order 0,1,2,3, each 3 contiguous beats, one idle cycle between packets.
    run_until(12, 80);
    for (int s = 0; s < N; s++)
      for (int b = 0; b < 3; b++)
        chk_beat($sformatf("t1_s%0d_b%0d", s, b), s * 3 + b, 4'(1 << s), s, 0, b, b == 0, b == 2);
    for (int i = 1; i < 12; i++)
      chk_eq($sformatf("t1_gap%0d", i), q[i].cyc - q[i-1].cyc, (i % 3 == 0) ? 2 : 1);

    // Sink 2 five-beat packet locked while sink 0 requests; sink 0 follows.
    q.delete();
    start_pkt(2, 5, 1);
    step();
    step();
    start_pkt(0, 2, 1);
    run_until(7, 60);
    for (int b = 0; b < 5; b++)
      chk_beat($sformatf("t2_s2_b%0d", b), b, 4'b0100, 2, 1, b, b == 0, b == 4);
    for (int b = 0; b < 2; b++)
      chk_beat($sformatf("t2_s0_b%0d", b), 5 + b, 4'b0001, 0, 1, b, b == 0, b == 1);

    // Source ready toggling every cycle during a 4-beat packet from sink 1.
    q.delete();
    mirror_err = 0;
    tog_rdy = 1;
    start_pkt(1, 4, 1);
    run_until(4, 40);
    tog_rdy = 0;
    for (int b = 0; b < 4; b++)
      chk_beat($sformatf("t3_b%0d", b), b, 4'b0010, 1, 1, b, b == 0, b == 3);
    chk_eq("t3_span", q[3].cyc - q[0].cyc, 6);
    chk_eq("t3_ready_mirror_err", mirror_err, 0);

    // Asynchronous reset while beat 2 of a sink-2 packet is on the bus.
    q.delete();
    start_pkt(2, 4, 1);
    for (int i = 0; i < 20 && beat[2] != 2; i++) step();
    chk_eq("t4_reach_beat2", beat[2], 2);
    chk_eq("t4_pre_valid", ast_if.ast_source_valid_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    chk_eq("t4_grant", grant_o, 4'b0000);
    chk_eq("t4_src", {ast_if.ast_source_valid_o, ast_if.ast_source_startofpacket_o,
                      ast_if.ast_source_endofpacket_o, ast_if.ast_source_empty_o,
                      ast_if.ast_source_data_o}, 12'h000);
    chk_eq("t4_sink_rdy", ast_if.ast_sink_ready_o, 4'b0000);
    chk_eq("t4_rr_ptr", dut.rr_ptr_q, 2'd0);
    for (int s = 0; s < N; s++) begin
      pend[s] = 0; en[s] = 0; beat[s] = 0; pk[s] = 0; held[s] = 0;
    end
    drive();
    @(negedge clk_i);
    rst_i = 1'b0;
    q.delete();
    start_pkt(1, 1, 1);
    start_pkt(3, 1, 1);
    run_until(2, 30);
    chk_beat("t4_first_s1", 0, 4'b0010, 1, 0, 0, 1'b1, 1'b1);
    chk_beat("t4_then_s3", 1, 4'b1000, 3, 0, 0, 1'b1, 1'b1);

    // Only sink 1, three single-beat packets: one bubble each, pointer parks at 2.
    q.delete();
    start_pkt(1, 1, 3);
    run_until(3, 30);
    for (int i = 0; i < 3; i++)
      chk_beat($sformatf("t5_p%0d", i), i, 4'b0010, 1, 1 + i, 0, 1'b1, 1'b1);
    chk_eq("t5_gap1", q[1].cyc - q[0].cyc, 2);
    chk_eq("t5_gap2", q[2].cyc - q[1].cyc, 2);
    step();
    chk_eq("t5_rr_ptr", dut.rr_ptr_q, 2'd2);
    chk_eq("t5_idle_grant", grant_o, 4'b0000);

`ifdef ARB_PKT_TIMEOUT_EN
    // Sink 3 stalls after SOP; watchdog fires on stall cycle 8, then sink 0 is served.
    q.delete();
    to_pulses = 0;
    hold_after_sop[3] = 1;
    start_pkt(3, 4, 1);
    start_pkt(0, 1, 1);
    run_until(2, 60);
    chk_beat("t6_s3_sop", 0, 4'b1000, 3, 1, 0, 1'b1, 1'b0);
    chk_beat("t6_s0_next", 1, 4'b0001, 0, 0, 0, 1'b1, 1'b1);
    chk_eq("t6_pulses", to_pulses, 1);
    chk_eq("t6_pulse_at", to_cyc - q[0].cyc, 8);
    chk_eq("t6_regrant", q[1].cyc - to_cyc, 2);
    en[3] = 0;
    held[3] = 0;
    hold_after_sop[3] = 0;
    step();
`else
    chk_eq("no_timeout_pulses", to_pulses, 0);
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
